// File: rtl/avalon_mem_responder.sv
// Avalon-MM word memory target with fixed wait-state insertion.
// Flags initiator protocol violations in a sticky error bit.
module avalon_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t state, nstate;
  logic [3:0]  cnt, ncnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic req;
  logic wreq;
  logic latch;
  logic load;
  logic err_set;
  logic mem_we;
  logic [DEPTH_LOG2-1:0] idx_in, idx_q, rd_idx;

  assign req    = read | write;
  assign idx_in = DEPTH_LOG2'((address - BASE_ADDR) >> 2);
  assign idx_q  = DEPTH_LOG2'((addr_q - BASE_ADDR) >> 2);
  assign rd_idx = (state == S_IDLE) ? idx_in : idx_q;

  // Wait is held high throughout reset regardless of the FSM.
  assign waitrequest = wreq | ~rst_n;

  // Next-state, wait counting and protocol checks.
  always_comb begin
    nstate  = state;
    ncnt    = cnt;
    wreq    = 1'b1;
    latch   = 1'b0;
    load    = 1'b0;
    err_set = 1'b0;
    mem_we  = 1'b0;
    case (state)
      S_IDLE: begin
        wreq = req;
        if (req) begin
          latch  = 1'b1;
          ncnt   = 4'd1;
          nstate = (WC == 4'd1) ? S_DONE : S_WAIT;
          if ((read && write) || (address[1:0] != 2'b00))
            err_set = 1'b1;
          if ((WC == 4'd1) && read && !write)
            load = 1'b1;
        end
      end
      S_WAIT: begin
        if (!req) begin
          nstate  = S_IDLE;
          ncnt    = 4'd0;
          err_set = 1'b1;
        end else begin
          if ((address != addr_q) || (read != rd_q) ||
              (write != wr_q) || (writedata != wdata_q))
            err_set = 1'b1;
          ncnt = cnt + 4'd1;
          if (ncnt == WC) begin
            nstate = S_DONE;
            load   = rd_q && !wr_q;
          end
        end
      end
      S_DONE: begin
        wreq   = 1'b0;
        mem_we = wr_q;
        nstate = S_IDLE;
        ncnt   = 4'd0;
      end
      default: begin
        nstate = S_IDLE;
        ncnt   = 4'd0;
      end
    endcase
  end

  // State, request capture, read data and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      readdata     <= 32'd0;
      protocol_err <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      if (latch) begin
        addr_q  <= address;
        wdata_q <= writedata;
        be_q    <= byteenable;
        rd_q    <= read;
        wr_q    <= write;
      end
      if (load)
        readdata <= mem[rd_idx];
      if (err_set)
        protocol_err <= 1'b1;
    end
  end

  // Byte-lane write on the completion edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k])
          mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder.
// Hand-computed expectations, single check task.
module tb_avalon_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        protocol_err;

  int checks = 0;
  int failures = 0;

  avalon_mem_responder #(
    .BASE_ADDR  (32'hBFC0_0000),
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic xfer(input string tag,
                      input logic [31:0] a,
                      input logic r,
                      input logic w,
                      input logic [3:0] b,
                      input logic [31:0] d,
                      input logic ck,
                      input logic [31:0] exp);
    address    = a;
    read       = r;
    write      = w;
    byteenable = b;
    writedata  = d;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk({tag, "_wr_hi"}, 32'(waitrequest), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_wr_lo"}, 32'(waitrequest), 32'd0);
    if (ck)
      chk({tag, "_rdata"}, readdata, exp);
    @(posedge clk); #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    address    = 32'd0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'd0;
    writedata  = 32'd0;
    #12;
    chk("rst_wr", 32'(waitrequest), 32'd1);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_err", 32'(protocol_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_wr", 32'(waitrequest), 32'd0);

    xfer("w_dead", 32'hBFC0_0010, 1'b0, 1'b1, 4'hF,
         32'hDEAD_BEEF, 1'b0, 32'd0);
    xfer("r_dead", 32'hBFC0_0010, 1'b1, 1'b0, 4'h0,
         32'd0, 1'b1, 32'hDEAD_BEEF);
    chk("dead_err", 32'(protocol_err), 32'd0);

    xfer("w_base", 32'hBFC0_0020, 1'b0, 1'b1, 4'hF,
         32'h1122_3344, 1'b0, 32'd0);
    xfer("w_part", 32'hBFC0_0020, 1'b0, 1'b1, 4'b0101,
         32'hAABB_CCDD, 1'b0, 32'd0);
    xfer("r_part", 32'hBFC0_0020, 1'b1, 1'b0, 4'h0,
         32'd0, 1'b1, 32'h11BB_33DD);

    xfer("w_be0", 32'hBFC0_0010, 1'b0, 1'b1, 4'h0,
         32'h0BAD_F00D, 1'b0, 32'd0);
    xfer("r_be0", 32'hBFC0_0010, 1'b1, 1'b0, 4'h0,
         32'd0, 1'b1, 32'hDEAD_BEEF);

    xfer("w_wrap", 32'hBFC0_1004, 1'b0, 1'b1, 4'hF,
         32'h5A5A_5A5A, 1'b0, 32'd0);
    xfer("r_wrap", 32'hBFC0_0004, 1'b1, 1'b0, 4'h0,
         32'd0, 1'b1, 32'h5A5A_5A5A);
    chk("clean_err", 32'(protocol_err), 32'd0);

    // Reset in the middle of a held write.
    xfer("w_zero", 32'hBFC0_0030, 1'b0, 1'b1, 4'hF,
         32'h0, 1'b0, 32'd0);
    address    = 32'hBFC0_0030;
    write      = 1'b1;
    byteenable = 4'hF;
    writedata  = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mr_c0_wr", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_wr", 32'(waitrequest), 32'd1);
    chk("mr_rst_rdata", readdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mr_rst_wr2", 32'(waitrequest), 32'd1);
    rst_n = 1'b1;
    #1;
    chk("mr_rel_wr", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_c1_wr", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_c2_wr", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    write = 1'b0;
    @(negedge clk);
    chk("mr_idle_wr", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    xfer("r_mr", 32'hBFC0_0030, 1'b1, 1'b0, 4'h0,
         32'd0, 1'b1, 32'hFFFF_FFFF);
    chk("mr_err", 32'(protocol_err), 32'd0);

    // Dropped read during wait.
    xfer("r_pre", 32'hBFC0_0004, 1'b1, 1'b0, 4'h0,
         32'd0, 1'b1, 32'h5A5A_5A5A);
    address = 32'hBFC0_0010;
    read    = 1'b1;
    @(negedge clk);
    chk("drop_c0_wr", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    chk("drop_c1_wr", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_idle_wr", 32'(waitrequest), 32'd0);
    chk("drop_err", 32'(protocol_err), 32'd1);
    chk("drop_rdata", readdata, 32'h5A5A_5A5A);
    repeat (4) @(posedge clk);
    #1;
    chk("drop_sticky", 32'(protocol_err), 32'd1);
    chk("drop_rdata2", readdata, 32'h5A5A_5A5A);

    // Read and write together behaves as a write.
    do_reset();
    chk("both_pre_err", 32'(protocol_err), 32'd0);
    xfer("both", 32'hBFC0_0040, 1'b1, 1'b1, 4'hF,
         32'h1234_5678, 1'b1, 32'd0);
    chk("both_err", 32'(protocol_err), 32'd1);
    xfer("r_both", 32'hBFC0_0040, 1'b1, 1'b0, 4'h0,
         32'd0, 1'b1, 32'h1234_5678);

    // Misaligned read uses the aligned word.
    do_reset();
    chk("mis_pre_err", 32'(protocol_err), 32'd0);
    xfer("r_mis", 32'hBFC0_0012, 1'b1, 1'b0, 4'h0,
         32'd0, 1'b1, 32'hDEAD_BEEF);
    chk("mis_err", 32'(protocol_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
